// File: rtl/tm1637_tx.sv
// -----------------------------------------------------------------------------
// tm1637_tx
// Byte-level serial transmitter for the TM1637 LED driver. A byte is taken
// over a valid/ready handshake and sent as: start condition (only when the
// bus is idle), 8 data bits LSB first, an ACK clock, then an optional stop.
// If the stop is withheld, the bus is parked (CLK=0, DIO=0) until the next
// byte arrives, which continues the same transaction without a new start.
//
// Parameters:
//   HALF_PERIOD  clk_50M cycles per bus phase (minimum 2, default 250)
//
// Ports:
//   clk_50M        in   system clock
//   rst_n          in   asynchronous active-low reset
//   in_data[7:0]   in   byte to send
//   in_start       in   request start (start is implied from idle, so unused)
//   in_stop        in   follow the byte with a stop condition
//   in_valid       in   byte offered
//   in_ready       out  byte can be accepted this cycle (IDLE or HOLD)
//   tm1637_clk     out  bus clock (registered)
//   tm1637_dio     out  bus data, 1 = released (registered)
//   tm1637_dio_in  in   sampled bus data for the ACK bit
//   busy           out  transaction in progress
//   done           out  one-cycle pulse in the last cycle of each ACK phase
//   ack_err        out  NACK status of the last byte, updated with done
//
// Build option:
//   TM1637_ACK_CHECK_EN  when defined, ack_err samples tm1637_dio_in at done;
//                        otherwise ack_err is tied low.
// -----------------------------------------------------------------------------
module tm1637_tx #(
    parameter int HALF_PERIOD = 250
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_start,
    input  logic       in_stop,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tm1637_clk,
    output logic       tm1637_dio,
    input  logic       tm1637_dio_in,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    // state    | meaning
    // ---------+---------------------------------------------------
    // IDLE     | bus released (CLK=1, DIO=1), waiting for a byte
    // START    | start condition: DIO low while CLK high
    // BIT_LO   | CLK low, DIO = current data bit
    // BIT_HI   | CLK high, DIO held; shift after the phase
    // ACK_LO   | CLK low, DIO released for the slave ACK
    // ACK_HI   | CLK high, ACK sampled / done in the last cycle
    // HOLD     | bus parked (CLK=0, DIO=0) between bytes, no stop
    // STOP_A   | CLK low, DIO low
    // STOP_B   | CLK high, DIO low
    // STOP_C   | CLK high, DIO high (stop), then IDLE
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_BIT_LO = 4'd2;
    localparam logic [3:0] S_BIT_HI = 4'd3;
    localparam logic [3:0] S_ACK_LO = 4'd4;
    localparam logic [3:0] S_ACK_HI = 4'd5;
    localparam logic [3:0] S_HOLD   = 4'd6;
    localparam logic [3:0] S_STOP_A = 4'd7;
    localparam logic [3:0] S_STOP_B = 4'd8;
    localparam logic [3:0] S_STOP_C = 4'd9;

    localparam int              CW      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0]   PH_LAST = CW'(HALF_PERIOD - 1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_q, stop_d;
    logic          clk_q, clk_d;
    logic          dio_q, dio_d;

    logic timed;
    logic phase_end;
    logic accept;

    // Start is generated from IDLE unconditionally and never from HOLD,
    // so the start request carries no information here.
    logic unused_in_start;
    assign unused_in_start = in_start;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign timed     = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign phase_end = timed && (cnt_q == PH_LAST);
    assign done      = (state_q == S_ACK_HI) && phase_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        stop_d  = stop_q;

        if (timed) begin
            cnt_d = phase_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shift_d = in_data;
                    stop_d  = in_stop;
                    bit_d   = '0;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    state_d = S_BIT_LO;
                    shift_d = in_data;
                    stop_d  = in_stop;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (phase_end) state_d = S_BIT_LO;
            end
            S_BIT_LO: begin
                if (phase_end) state_d = S_BIT_HI;
            end
            S_BIT_HI: begin
                if (phase_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_ACK_LO;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_BIT_LO;
                    end
                end
            end
            S_ACK_LO: begin
                if (phase_end) state_d = S_ACK_HI;
            end
            S_ACK_HI: begin
                if (phase_end) state_d = stop_q ? S_STOP_A : S_HOLD;
            end
            S_STOP_A: begin
                if (phase_end) state_d = S_STOP_B;
            end
            S_STOP_B: begin
                if (phase_end) state_d = S_STOP_C;
            end
            S_STOP_C: begin
                if (phase_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin levels are a function of the current state and are registered,
    // so the bus lags the state by one cycle without changing phase lengths.
    always_comb begin
        clk_d = 1'b1;
        dio_d = 1'b1;
        case (state_q)
            S_START: begin
                dio_d = 1'b0;
            end
            S_BIT_LO: begin
                clk_d = 1'b0;
                dio_d = shift_q[0];
            end
            S_BIT_HI: begin
                dio_d = shift_q[0];
            end
            S_ACK_LO: begin
                clk_d = 1'b0;
            end
            S_HOLD, S_STOP_A: begin
                clk_d = 1'b0;
                dio_d = 1'b0;
            end
            S_STOP_B: begin
                dio_d = 1'b0;
            end
            default: begin
                clk_d = 1'b1;
                dio_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stop_q  <= 1'b0;
            clk_q   <= 1'b1;
            dio_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stop_q  <= stop_d;
            clk_q   <= clk_d;
            dio_q   <= dio_d;
        end
    end

    assign tm1637_clk = clk_q;
    assign tm1637_dio = dio_q;

`ifdef TM1637_ACK_CHECK_EN
    logic ack_err_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            ack_err_q <= 1'b0;
        end else if (done) begin
            ack_err_q <= tm1637_dio_in;
        end
    end

    assign ack_err = ack_err_q;
`else
    logic unused_dio_in;
    assign unused_dio_in = tm1637_dio_in;
    assign ack_err       = 1'b0;
`endif

endmodule

// File: tb/tb_tm1637_tx.sv
module tb_tm1637_tx;

    localparam int HP      = 4;
    localparam int T_START = 256;
    localparam int T_STOP  = 257;
    localparam int T_NACK  = 512;
`ifdef TM1637_ACK_CHECK_EN
    localparam bit ACK_ON = 1'b1;
`else
    localparam bit ACK_ON = 1'b0;
`endif

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_start;
    logic       in_stop;
    logic       in_valid;
    logic       in_ready;
    logic       tm1637_clk;
    logic       tm1637_dio;
    logic       tm1637_dio_in;
    logic       busy;
    logic       done;
    logic       ack_err;

    tm1637_tx #(.HALF_PERIOD(HP)) dut (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_start      (in_start),
        .in_stop       (in_stop),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tm1637_clk    (tm1637_clk),
        .tm1637_dio    (tm1637_dio),
        .tm1637_dio_in (tm1637_dio_in),
        .busy          (busy),
        .done          (done),
        .ack_err       (ack_err)
    );

    initial forever #5 clk_50M = ~clk_50M;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mon_q[$];
    bit m_open = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic       stop;
        logic       nack;
        int         exp_lat;
    } vec_t;
    vec_t vt[6];

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic string q2s(input int q[$]);
        string s = "";
        foreach (q[i]) if (i < 12) s = {s, $sformatf(" %0h", q[i])};
        return s;
    endfunction

    task automatic check_tokens(input string name);
        bit ok;
        ok = (mon_q.size() == exp_q.size());
        if (ok) foreach (exp_q[i]) if (mon_q[i] != exp_q[i]) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: bus tokens got [%s ] expected [%s ]", name, q2s(mon_q), q2s(exp_q));
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    // Bus decoder: turns pin activity into START / byte / STOP tokens.
    initial begin
        bit       pc, pd;
        int       nb;
        bit [7:0] sh;
        pc = 1'b1; pd = 1'b1; nb = 0; sh = '0;
        forever begin
            @(negedge clk_50M);
            if (!rst_n) begin
                mon_q.delete();
                pc = 1'b1; pd = 1'b1; nb = 0;
            end else begin
                if (pc && tm1637_clk && pd && !tm1637_dio) begin
                    mon_q.push_back(T_START);
                    nb = 0;
                end else if (pc && tm1637_clk && !pd && tm1637_dio) begin
                    mon_q.push_back(T_STOP);
                end else if (!pc && tm1637_clk) begin
                    if (nb < 8) begin
                        sh[nb] = tm1637_dio;
                        nb++;
                    end else begin
                        mon_q.push_back(tm1637_dio ? int'(sh) : T_NACK + int'(sh));
                        nb = 0;
                    end
                end
                pc = tm1637_clk;
                pd = tm1637_dio;
            end
        end
    end

    task automatic garbage();
        in_data  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        in_stop  = 1'($urandom);
        in_start = 1'($urandom);
    endtask

    // Offers one byte (expected to be accepted immediately), checks done
    // latency, ack_err, ready/stop timing; optionally keeps in_valid high
    // with junk while the transfer is in flight.
    task automatic send(input logic [7:0] d, input logic s, input logic p, input logic nack,
                        input int exp_lat, input bit hold_valid, input string name);
        int n;
        if (!m_open) exp_q.push_back(T_START);
        exp_q.push_back(int'(d));
        if (p) exp_q.push_back(T_STOP);
        m_open = !p;
        in_data = d; in_start = s; in_stop = p; in_valid = 1'b1; tm1637_dio_in = nack;
        n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        chk({name, "_wait"}, n, 0);
        tick();
        n = 1;
        if (hold_valid) garbage(); else in_valid = 1'b0;
        while (!done && n < 400) begin
            tick();
            n++;
            if (hold_valid) garbage();
        end
        chk({name, "_done_lat"}, n, exp_lat);
        tick();
        chk({name, "_ack_err"}, int'(ack_err), int'(nack & ACK_ON));
        chk({name, "_ready_after"}, int'(in_ready), int'(!p));
        if (p) begin
            n = 0;
            while (!in_ready && n < 100) begin
                if (hold_valid) garbage();
                tick();
                n++;
            end
            chk({name, "_stop_len"}, n, 3 * HP);
            chk({name, "_idle_busy"}, int'(busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, nd, lat;
        logic [7:0] d;
        logic s, p, k;
        bit bpv;

        vt[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 19 * HP};
        vt[1] = '{8'hC0, 1'b1, 1'b0, 1'b0, 19 * HP};
        vt[2] = '{8'h3F, 1'b0, 1'b0, 1'b1, 18 * HP};
        vt[3] = '{8'h06, 1'b1, 1'b1, 1'b0, 18 * HP};
        vt[4] = '{8'h5B, 1'b0, 1'b1, 1'b1, 19 * HP};
        vt[5] = '{8'h88, 1'b1, 1'b1, 1'b0, 19 * HP};

        rst_n = 1'b0; in_data = '0; in_start = 1'b0; in_stop = 1'b0;
        in_valid = 1'b0; tm1637_dio_in = 1'b0;
        tick(); tick();
        chk("rst_clk", int'(tm1637_clk), 1);
        chk("rst_dio", int'(tm1637_dio), 1);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        rst_n = 1'b1;
        tick();

        // Single framed byte: busy length and a single done pulse.
        in_data = 8'h40; in_start = 1'b1; in_stop = 1'b1; in_valid = 1'b1; tm1637_dio_in = 1'b0;
        chk("a_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        nb = 0; nd = 0;
        for (int i = 0; i < 100; i++) begin
            nb += int'(busy);
            nd += int'(done);
            tick();
        end
        chk("a_busy_cycles", nb, 22 * HP);
        chk("a_done_pulses", nd, 1);
        chk("a_ack_err", int'(ack_err), 0);
        exp_q.push_back(T_START); exp_q.push_back(8'h40); exp_q.push_back(T_STOP);
        check_tokens("a_tokens");

        // Vector table.
        for (int i = 0; i < 6; i++) begin
            send(vt[i].data, vt[i].start, vt[i].stop, vt[i].nack, vt[i].exp_lat, 1'b0,
                 $sformatf("vec%0d", i));
            check_tokens($sformatf("vec%0d_tokens", i));
        end

        // Multi-byte: next byte offered in the done cycle, accepted from HOLD.
        in_data = 8'hC0; in_start = 1'b1; in_stop = 1'b0; in_valid = 1'b1; tm1637_dio_in = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!done && n < 400) begin tick(); n++; end
        chk("mb_lat0", n, 19 * HP);
        in_data = 8'h3F; in_start = 1'b0; in_stop = 1'b0; in_valid = 1'b1;
        chk("mb_ready_at_done", int'(in_ready), 0);
        tick();
        chk("mb_ready_hold", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!done && n < 400) begin tick(); n++; end
        chk("mb_lat1", n, 18 * HP);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mb_hold_clk%0d", i), int'(tm1637_clk), 0);
            chk($sformatf("mb_hold_dio%0d", i), int'(tm1637_dio), 0);
        end
        exp_q.push_back(T_START); exp_q.push_back(8'hC0); exp_q.push_back(8'h3F);
        m_open = 1'b1;
        send(8'h06, 1'b1, 1'b1, 1'b0, 18 * HP, 1'b0, "mb_last");
        check_tokens("mb_tokens");

        // Back-pressure: in_valid stays high with junk while not ready.
        send(8'h12, 1'b1, 1'b0, 1'b0, 19 * HP, 1'b1, "bp0");
        send(8'h34, 1'b0, 1'b0, 1'b1, 18 * HP, 1'b1, "bp1");
        send(8'h7E, 1'b0, 1'b1, 1'b0, 18 * HP, 1'b1, "bp2");
        in_valid = 1'b0;
        check_tokens("bp_tokens");

        // Randomized bytes against the framing model.
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom);
            s   = 1'($urandom);
            p   = ($urandom_range(0, 2) == 0);
            k   = 1'($urandom);
            bpv = 1'($urandom);
            lat = m_open ? 18 * HP : 19 * HP;
            send(d, s, p, k, lat, bpv, $sformatf("rnd%0d", i));
            in_valid = 1'b0;
            check_tokens($sformatf("rnd%0d_tokens", i));
        end
        if (m_open) begin
            send(8'($urandom), 1'b0, 1'b1, 1'b0, 18 * HP, 1'b0, "rnd_close");
            check_tokens("rnd_close_tokens");
        end

        // Reset in the middle of bit 3.
        in_data = 8'hF0; in_start = 1'b1; in_stop = 1'b1; in_valid = 1'b1; tm1637_dio_in = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        chk("mr_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_clk", int'(tm1637_clk), 1);
        chk("mr_dio", int'(tm1637_dio), 1);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ready", int'(in_ready), 1);
        tick(); tick();
        chk("mr_clk_held", int'(tm1637_clk), 1);
        rst_n = 1'b1;
        m_open = 1'b0;
        exp_q.delete();
        tick();
        send(8'h88, 1'b1, 1'b1, 1'b0, 19 * HP, 1'b0, "mr_after");
        check_tokens("mr_tokens");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
